// File: rtl/bit16_deserializer_pkg.sv
// ----------------------------------------------------------------------------
// bit16_deserializer_pkg
// Shared constants and helpers for the 16-bit serial-to-parallel deserializer.
//   WORD_W   : width of an assembled word
//   CNT_W    : width of the bit counter (indexes 0..WORD_W-1)
//   CNT_LAST : counter value of the final bit of a word
//   bit_pos(): shift-register slot for the bit at counter value cnt
// ----------------------------------------------------------------------------
package bit16_deserializer_pkg;

    localparam int WORD_W = 16;
    localparam int CNT_W  = 4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    // LSB-first words fill slot cnt; MSB-first words fill slot (WORD_W-1)-cnt.
    function automatic logic [CNT_W-1:0] bit_pos(input logic             lsb_first,
                                                 input logic [CNT_W-1:0] cnt);
        return lsb_first ? cnt : (CNT_LAST - cnt);
    endfunction

endpackage

// File: rtl/bit16_deserializer_or16way.sv
// ----------------------------------------------------------------------------
// Or16Way
// Full-width OR reduction; reports whether any bit of the input word is set.
// Ports:
//   in  : WORD_W-bit word to reduce
//   out : 1 when any bit of in is 1
// ----------------------------------------------------------------------------
module Or16Way
    import bit16_deserializer_pkg::*;
(
    input  logic [WORD_W-1:0] in,
    output logic              out
);

    assign out = |in;

endmodule

// File: rtl/bit16_deserializer.sv
// ----------------------------------------------------------------------------
// bit16_deserializer
// Collects serial bits into WORD_W-bit words. Bits are accepted with a
// valid/ready handshake; a finished word is parked in a holding register and
// offered with a valid/ready handshake. A new word can be assembled while
// the previous one waits; only the final bit of the next word is stalled.
// Ports:
//   clk         : clock, rising-edge active
//   rst_n       : asynchronous active-low reset
//   flush       : discard the partially assembled word
//   in_bit      : serial data bit
//   in_valid    : in_bit is valid
//   in_ready    : block can accept in_bit this cycle
//   out_data    : assembled word (holding register)
//   out_valid   : out_data holds an unconsumed word
//   out_ready   : consumer takes out_data this cycle
//   out_nonzero : OR of all bits of out_data
// Parameter:
//   LSB_FIRST   : 1 = first bit lands in out_data[0], 0 = in out_data[15]
// ----------------------------------------------------------------------------
module bit16_deserializer
    import bit16_deserializer_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_bit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_nonzero
);

    logic [CNT_W-1:0]  cnt_reg,   cnt_next;
    logic [WORD_W-1:0] shift_reg, shift_next;
    logic [WORD_W-1:0] hold_reg,  hold_next;
    logic              full_reg,  full_next;

    logic              bit_xfer;
    logic              word_xfer;
    logic [CNT_W-1:0]  slot;
    logic [WORD_W-1:0] merged;

    // The last bit of a word can only be taken if the holding register is
    // free or being emptied on the same edge; earlier bits are never stalled.
    assign in_ready  = !((cnt_reg == CNT_LAST) && full_reg && !out_ready);
    assign bit_xfer  = in_valid && in_ready;
    assign word_xfer = full_reg && out_ready;

    assign slot = bit_pos(LSB_FIRST, cnt_reg);

    // Shift register with the incoming bit dropped into its slot. On the
    // completing edge this is the finished word that goes to the holding reg.
    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_merge
            assign merged[gi] = (slot == CNT_W'(gi)) ? in_bit : shift_reg[gi];
        end
    endgenerate

    always_comb begin
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        hold_next  = hold_reg;
        full_next  = full_reg;

        if (word_xfer) begin
            full_next = 1'b0;
        end

        // flush wins over a bit transfer; holding register is untouched.
        if (flush) begin
            cnt_next   = '0;
            shift_next = '0;
        end else if (bit_xfer) begin
            if (cnt_reg == CNT_LAST) begin
                // Completion overrides a same-edge consume: no bubble.
                cnt_next   = '0;
                shift_next = '0;
                hold_next  = merged;
                full_next  = 1'b1;
            end else begin
                cnt_next   = cnt_reg + CNT_W'(1);
                shift_next = merged;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            shift_reg <= '0;
            hold_reg  <= '0;
            full_reg  <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
            hold_reg  <= hold_next;
            full_reg  <= full_next;
        end
    end

    assign out_data  = hold_reg;
    assign out_valid = full_reg;

    Or16Way u_or16way (
        .in  (hold_reg),
        .out (out_nonzero)
    );

endmodule

// File: doc/bit16_deserializer.md
BIT16_DESERIALIZER -- requirements
Module: bit16_deserializer

Interface
REQ-001 Parameter: LSB_FIRST, default 1; 1 means the first accepted bit lands in out_data[0], 0 means it lands in out_data[15].
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  synchronous discard of the partially assembled word.
REQ-005 in_bit  input  1  serial data bit.
REQ-006 in_valid  input  1  in_bit is valid this cycle.
REQ-007 in_ready  output  1  block can accept in_bit this cycle.
REQ-008 out_data  output  16  assembled word.
REQ-009 out_valid  output  1  out_data holds an unconsumed word.
REQ-010 out_ready  input  1  consumer accepts out_data this cycle.
REQ-011 out_nonzero  output  1  OR of all 16 bits of out_data; valid whenever out_valid=1.

Function
REQ-012 A bit transfers when in_valid and in_ready are both 1 on a rising edge; a word transfers when out_valid and out_ready are both 1.
REQ-013 Internal state: 16-bit shift register, 4-bit bit counter cnt (0..15), 16-bit output holding register, and a full flag driving out_valid.
REQ-014 Each accepted bit is placed in shift-register position cnt (LSB_FIRST=1) or 15-cnt (LSB_FIRST=0), and cnt increments.
REQ-015 Accepting a bit with cnt=15 completes the word: cnt wraps to 0, and the complete word (including that bit) loads the holding register with out_valid=1 on the same edge.
REQ-016 Latency: out_valid rises on the clock edge that accepts the 16th bit, so the word is visible in the following cycle.
REQ-017 in_ready = NOT (cnt=15 AND out_valid=1 AND out_ready=0); this is the only back-pressure condition.
REQ-018 Bits 0..14 of a new word are accepted while a previous word is still waiting in the holding register.
REQ-019 Simultaneous word accept and word completion on one edge: the holding register loads the new word, out_valid stays 1, and no bubble or loss occurs.
REQ-020 A word accept without a completion on the same edge clears out_valid on that edge.
REQ-021 out_data and out_nonzero hold stable while out_valid=1 and out_ready=0.
REQ-022 flush=1 on an edge: cnt is set to 0 and the shift register is cleared; in_bit is ignored that cycle.
REQ-023 flush does not affect the holding register or out_valid; a pending word survives flush.
REQ-024 flush takes priority over a bit transfer on the same edge; in_ready remains per REQ-017.
REQ-025 out_nonzero is combinational from the holding register, and no other output is combinational from in_valid.

Reset
REQ-026 While rst_n=0: cnt=0, shift register=0, holding register=0, out_valid=0, out_nonzero=0, in_ready=1.
REQ-027 Asserting rst_n mid-word or with a pending word discards all data immediately, without waiting for clk.
REQ-028 Deassertion is sampled synchronously; the first bit may be accepted on the first rising edge with rst_n=1.

Structure
REQ-029 A shared package/header defines WORD_W=16 and CNT_W=4; this block uses those constants and no literals.
REQ-030 The 16-bit OR reduction for out_nonzero is one sub-module instance, Or16Way (in = holding register, out = out_nonzero).
REQ-031 The block contains no other sub-modules.

Verification
REQ-032 Reset, then stream 16'hA5C3 LSB-first with in_valid held high and out_ready=1 -> out_valid pulses 1 for one cycle after the 16th bit, with out_data=16'hA5C3 and out_nonzero=1.
REQ-033 Stream 16 zero bits -> out_data=16'h0000 with out_nonzero=0; then with LSB_FIRST=0 stream 16'h8001 MSB-first -> out_data=16'h8001.
REQ-034 Hold out_ready=0 and stream 32 bits (16'h1234 then 16'hFFFF) -> in_ready drops to 0 at cnt=15 of the second word while out_data stays 16'h1234. Then raise out_ready -> in the same cycle 16'h1234 is consumed and 16'hFFFF is loaded, with out_valid continuously 1.
REQ-035 Send 7 bits, assert flush for one cycle, then send 16'h00F0 -> out_data=16'h00F0 with no residue from the flushed bits; a pending word present during the flush still reads out unchanged.
REQ-036 Pull rst_n low asynchronously, between clock edges, after 9 bits with a word pending -> out_valid=0 and in_ready=1 before the next edge; the next 16 bits form a fresh word.
